// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default operand width for seq_multiplier.
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/seq_multiplier_pp_row.sv
// pp_row: one partial-product row, the multiplicand gated by the current multiplier bit.
module pp_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b0,
  output logic [WIDTH-1:0] row
);
  assign row = a & {WIDTH{b0}};
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, one partial-product row per clock.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, row, a_in, b_in;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod_reg, prod_fin;
  logic [WIDTH:0] sum;
  logic [CNT_W-1:0] cnt;
  logic accept, last;
  pp_row #(.WIDTH(WIDTH)) u_pp_row (.a(a_reg), .b0(b_reg[0]), .row(row));
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, row};
  assign acc_nxt = {sum, acc[WIDTH-1:1]};
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign accept = state == IDLE && in_valid;
`ifdef SEQ_MULT_SIGNED_EN
  logic sign;
  assign a_in = a[WIDTH-1] ? -a : a;
  assign b_in = b[WIDTH-1] ? -b : b;
  assign prod_fin = sign ? -acc_nxt : acc_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sign <= 1'b0;
    else if (accept) sign <= a[WIDTH-1] ^ b[WIDTH-1];
`else
  assign a_in = a;
  assign b_in = b;
  assign prod_fin = acc_nxt;
`endif
  always_comb begin
    state_nxt = accept ? RUN :
                (state == RUN && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      prod_reg <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= a_in;
        b_reg <= b_in;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + CNT_W'(1);
        if (last) prod_reg <= prod_fin;
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign busy      = state == RUN;
  assign out_valid = state == DONE;
  assign product   = prod_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks on WIDTH=8 plus back-to-back streams on WIDTH=4 and WIDTH=16.
module tb_seq_multiplier;
  logic clk = 0, rst_n = 0;
  logic iv = 0, ordy = 1, ir, ov, bz;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic iv4 = 0, ordy4 = 0, ir4, ov4, bz4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] p4;
  logic iv16 = 0, ordy16 = 0, ir16, ov16, bz16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a8), .b(b8),
    .out_valid(ov), .out_ready(ordy), .product(p8), .busy(bz));
  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(ordy4), .product(p4), .busy(bz4));
  seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(ordy16), .product(p16), .busy(bz16));

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [15:0] E_FF = 16'd1;
`else
  localparam logic [15:0] E_FF = 16'hFE01;
`endif

  function automatic logic [7:0] m4(input logic [3:0] x, input logic [3:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [7:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    return {4'b0, x} * {4'b0, y};
`endif
  endfunction

  function automatic logic [31:0] m16(input logic [15:0] x, input logic [15:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [31:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    return {16'b0, x} * {16'b0, y};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] x, input logic [7:0] y);
    iv = 1; a8 = x; b8 = y;
    tick();
    iv = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = ov;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({ov, bz, p8} !== 18'd0) begin errors++; $display("FAIL reset_outputs: got ov=%b busy=%b p=%0h want 0 0 0", ov, bz, p8); end
    checks++; if ({ov4, ov16, p4, p16} !== 42'd0) begin errors++; $display("FAIL reset_other: got ov4=%b ov16=%b p4=%0h p16=%0h want zeros", ov4, ov16, p4, p16); end
    tick(); tick();
    rst_n = 1;
    tick();
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir); end
  endtask

  task automatic test_basic();
    bit bad = 0;
    start(8'd13, 8'd11);
    checks++; if ({bz, ov, ir} !== 3'b100) begin errors++; $display("FAIL run_first: got busy,ov,ir=%b want 100", {bz, ov, ir}); end
    for (int i = 0; i < 7; i++) begin
      tick();
      if ({bz, ov} !== 2'b10) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL run_busy_8: got early exit want busy for 8 cycles"); end
    tick();
    checks++; if ({ov, bz} !== 2'b10) begin errors++; $display("FAIL latency_9: got ov=%b busy=%b want 1 0", ov, bz); end
    checks++; if (p8 !== 16'd143) begin errors++; $display("FAIL prod_13x11: got %0d want 143", p8); end
    tick();
    checks++; if ({ov, ir} !== 2'b01) begin errors++; $display("FAIL back_to_idle: got ov=%b ir=%b want 0 1", ov, ir); end
  endtask

  task automatic test_vectors();
    bit ok;
    int n;
    start(8'hFF, 8'hFF);
    wait_done(ok);
    checks++; if (!ok || p8 !== E_FF) begin errors++; $display("FAIL prod_ffxff: got %0h want %0h (done=%b)", p8, E_FF, ok); end
    tick();
    start(8'd0, 8'd200);
    n = 1;
    ok = 0;
    while (!ok && n < 40) begin tick(); n++; ok = ov; end
    checks++; if (!ok || p8 !== 16'd0) begin errors++; $display("FAIL prod_0x200: got %0h want 0 (done=%b)", p8, ok); end
    checks++; if (n !== 9) begin errors++; $display("FAIL zero_full_length: got %0d edges want 9", n); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok, bad = 0;
    ordy = 0;
    start(8'd20, 8'd3);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done: got no out_valid want out_valid"); end
    for (int i = 0; i < 5; i++) begin
      iv = (i == 2); a8 = 8'd9; b8 = 8'd9;
      tick();
      if ({ov, ir, bz} !== 3'b100 || p8 !== 16'd60) bad = 1;
    end
    iv = 0;
    checks++; if (bad) begin errors++; $display("FAIL bp_hold: got ov=%b ir=%b p=%0d want held 1 0 60", ov, ir, p8); end
    ordy = 1;
    tick();
    checks++; if ({ov, ir} !== 2'b01) begin errors++; $display("FAIL bp_release: got ov=%b ir=%b want 0 1", ov, ir); end
    checks++; if (p8 !== 16'd60) begin errors++; $display("FAIL bp_keep_prod: got %0d want 60", p8); end
    tick();
    checks++; if ({bz, ir} !== 2'b01) begin errors++; $display("FAIL bp_no_queue: got busy=%b ir=%b want 0 1", bz, ir); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    start(8'd13, 8'd11);
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    checks++; if ({ov, bz, p8} !== 18'd0) begin errors++; $display("FAIL mid_reset: got ov=%b busy=%b p=%0h want 0 0 0", ov, bz, p8); end
    tick();
    rst_n = 1;
    tick();
    checks++; if ({ir, bz} !== 2'b10) begin errors++; $display("FAIL post_reset: got ir=%b busy=%b want 1 0", ir, bz); end
    start(8'd6, 8'd7);
    wait_done(ok);
    checks++; if (!ok || p8 !== 16'd42) begin errors++; $display("FAIL prod_6x7: got %0d want 42 (done=%b)", p8, ok); end
    tick();
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    bit ok;
    start(8'hFB, 8'd7);
    wait_done(ok);
    checks++; if (!ok || p8 !== 16'hFFDD) begin errors++; $display("FAIL s_m5x7: got %0h want ffdd", p8); end
    tick();
    start(8'h80, 8'h80);
    wait_done(ok);
    checks++; if (!ok || p8 !== 16'h4000) begin errors++; $display("FAIL s_m128xm128: got %0h want 4000", p8); end
    tick();
    start(8'hFF, 8'hFF);
    wait_done(ok);
    checks++; if (!ok || p8 !== 16'h0001) begin errors++; $display("FAIL s_m1xm1: got %0h want 1", p8); end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    fork
      begin
        logic [7:0] q[$];
        int n = 0, last = -1, cyc = 0;
        bit acc;
        a4 = 4'($urandom); b4 = 4'($urandom); iv4 = 1; ordy4 = 1;
        while (n < 100 && cyc < 4000) begin
          acc = ir4;
          tick(); cyc++;
          if (acc) begin q.push_back(m4(a4, b4)); a4 = 4'($urandom); b4 = 4'($urandom); end
          if (ov4) begin
            checks++; if (q.size() == 0 || p4 !== q[0]) begin errors++; $display("FAIL b2b_w4_prod: got %0h want %0h", p4, q.size() ? q[0] : 8'hx); end
            if (q.size()) void'(q.pop_front());
            if (last >= 0) begin checks++; if (cyc - last !== 6) begin errors++; $display("FAIL b2b_w4_rate: got %0d want 6", cyc - last); end end
            last = cyc; n++;
          end
        end
        checks++; if (n !== 100) begin errors++; $display("FAIL b2b_w4_count: got %0d want 100", n); end
        iv4 = 0;
      end
      begin
        logic [31:0] q[$];
        int n = 0, last = -1, cyc = 0;
        bit acc;
        a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1; ordy16 = 1;
        while (n < 100 && cyc < 4000) begin
          acc = ir16;
          tick(); cyc++;
          if (acc) begin q.push_back(m16(a16, b16)); a16 = 16'($urandom); b16 = 16'($urandom); end
          if (ov16) begin
            checks++; if (q.size() == 0 || p16 !== q[0]) begin errors++; $display("FAIL b2b_w16_prod: got %0h want %0h", p16, q.size() ? q[0] : 32'hx); end
            if (q.size()) void'(q.pop_front());
            if (last >= 0) begin checks++; if (cyc - last !== 18) begin errors++; $display("FAIL b2b_w16_rate: got %0d want 18", cyc - last); end end
            last = cyc; n++;
          end
        end
        checks++; if (n !== 100) begin errors++; $display("FAIL b2b_w16_count: got %0d want 100", n); end
        iv16 = 0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_mid_reset();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
